// File: rtl/rice_stream_decoder.sv
// Streaming Golomb-Rice decoder: two-word bit buffer, unary prefix via
// leading-zero count, k-bit remainder, valid/ready value output.

module count_lead_zero #(
  parameter int W_IN = 32
) (
  input  logic [W_IN-1:0]       in_i,
  output logic [$clog2(W_IN):0] cnt_o
);
  localparam int CW = $clog2(W_IN) + 1;

  // Highest set bit wins because it is visited last.
  always_comb begin
    cnt_o = CW'(W_IN);
    for (int i = 0; i < W_IN; i++) begin
      if (in_i[i]) cnt_o = CW'(W_IN - 1 - i);
    end
  end
endmodule

module rice_stream_decoder #(
  parameter int W_WORD = 32,
  parameter int W_VAL  = 32,
  parameter int K_MAX  = 15,
  parameter int Q_MAX  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_WORD-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        k,
  input  logic              flush,
  output logic [W_VAL-1:0]  out_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);
  localparam int BW = 2 * W_WORD;
  localparam int CW = $clog2(BW) + 1;
  localparam int ZW = $clog2(W_WORD) + 1;
  localparam int QW = $clog2(Q_MAX + 1);
  localparam logic [4:0] KMAX5 = 5'(K_MAX);

  typedef enum logic [1:0] {PREFIX, REM, EMIT, ERR} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [QW-1:0]     qacc_q, qacc_d;
  logic [4:0]        keff_q, keff_d;
  logic [W_VAL-1:0]  val_q, val_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;

  logic [ZW-1:0]     z;
  logic [CW-1:0]     cons;
  logic [CW-1:0]     cnt_mid;
  logic [BW-1:0]     bits_mid;
  logic              accept;
  logic [4:0]        kc;
  logic [K_MAX-1:0]  rtop, rem;
  logic [31:0]       wsum, zsum;

  count_lead_zero #(.W_IN(W_WORD)) u_clz (
    .in_i  (bits_q[BW-1 -: W_WORD]),
    .cnt_o (z)
  );

  assign in_ready  = (cnt_q <= CW'(W_WORD)) & ~err_q & ~flush;
  assign accept    = in_valid & in_ready;
  assign kc        = (k > KMAX5) ? KMAX5 : k;
  assign rtop      = bits_q[BW-1 -: K_MAX];
  assign rem       = rtop >> (KMAX5 - keff_q);
  assign wsum      = 32'(qacc_q) + 32'(W_WORD);
  assign zsum      = 32'(qacc_q) + 32'(z);
  assign out_value = val_q;
  assign out_valid = vld_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    qacc_d   = qacc_q;
    keff_d   = keff_q;
    val_d    = val_q;
    vld_d    = vld_q;
    err_d    = err_q;
    cons     = '0;
    unique case (state_q)
      PREFIX: begin
        if (cnt_q >= CW'(W_WORD)) begin
          if (qacc_q == '0) keff_d = kc;
          if (z == ZW'(W_WORD)) begin
            if (wsum > 32'(Q_MAX)) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              qacc_d = QW'(wsum);
              cons   = CW'(W_WORD);
            end
          end else if (zsum > 32'(Q_MAX)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            qacc_d  = QW'(zsum);
            cons    = CW'(z) + CW'(1);
            state_d = REM;
          end
        end
      end
      REM: begin
        if (cnt_q >= CW'(keff_q)) begin
          cons    = CW'(keff_q);
          val_d   = (W_VAL'(qacc_q) << keff_q) | W_VAL'(rem);
          vld_d   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          qacc_d  = '0;
          state_d = PREFIX;
        end
      end
      ERR: begin
        vld_d = 1'b0;
      end
    endcase

    // Consume from the pre-append contents, then place the new word
    // directly behind the surviving bits.
    bits_mid = bits_q << cons;
    cnt_mid  = cnt_q - cons;
    bits_d   = bits_mid;
    cnt_d    = cnt_mid;
    if (accept) begin
      bits_d = bits_mid | ({in_data, {W_WORD{1'b0}}} >> cnt_mid);
      cnt_d  = cnt_mid + CW'(W_WORD);
    end

    if (flush && state_q != ERR) begin
      bits_d  = '0;
      cnt_d   = '0;
      qacc_d  = '0;
      vld_d   = 1'b0;
      state_d = PREFIX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PREFIX;
      bits_q  <= '0;
      cnt_q   <= '0;
      qacc_q  <= '0;
      keff_q  <= '0;
      val_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      qacc_q  <= qacc_d;
      keff_q  <= keff_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_rice_stream_decoder.sv
// Directed bench for rice_stream_decoder with an output scoreboard.

module tb_rice_stream_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  k;
  logic        flush;
  logic [31:0] out_value;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  rice_stream_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k         (k),
    .flush     (flush),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out got=%0h exp=none", out_value);
        end
      end else begin
        chk("out_value", out_value, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    k         = 5'd0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step(1);

    // k=2: two planned symbols plus one formed from leftover bits
    k = 5'd2;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd100);
    send(32'h5800_0000);
    send(32'h8000_0000);
    drain("t1_drain");
    do_flush();

    // k=0: two all-zero passes then q=65
    k = 5'd0;
    exp_q.push_back(32'd65);
    send(32'h0000_0000);
    send(32'h0000_0000);
    send(32'h4000_0000);
    drain("t2_drain");
    chk("t2_err", 32'(err), 32'd0);
    do_flush();

    // flush mid-prefix clears q_acc
    k = 5'd0;
    send(32'h0000_0000);
    step(3);
    do_flush();
    exp_q.push_back(32'd0);
    send(32'h8000_0000);
    drain("t5_flush_drain");
    do_flush();

    // backpressure
    out_ready = 1'b0;
    k = 5'd2;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd100);
    send(32'h5800_0000);
    send(32'h8000_0000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_value", out_value, 32'd5);
      @(negedge clk);
    end
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("t4_drain");
    do_flush();

    // k change while symbol 1 waits in REM
    k = 5'd3;
    exp_q.push_back(32'd235);
    exp_q.push_back(32'd2);
    send(32'h0000_0005);
    step(4);
    k = 5'd1;
    send(32'hA000_0000);
    send(32'h0000_0000);
    drain("t6_drain");
    do_flush();

    // k above K_MAX clamps to 15
    k = 5'd20;
    exp_q.push_back(32'hBFFE);
    send(32'h5FFF_0000);
    drain("t6_clamp_drain");
    do_flush();

    // reset while waiting in REM
    k = 5'd15;
    send(32'h0000_0002);
    step(3);
    @(negedge clk);
    chk("t5_rem_wait", 32'(out_valid), 32'd0);
    chk("t5_pre_rst_value", out_value, 32'hBFFE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_value", out_value, 32'd0);
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    step(1);
    k = 5'd0;
    exp_q.push_back(32'd0);
    send(32'h8000_0000);
    drain("t5_post_rst_drain");
    do_flush();

    // quotient overflow
    k = 5'd0;
    for (int i = 0; i < 8; i++) send(32'h0000_0000);
    n = 0;
    @(negedge clk);
    while (!err && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t3_err_flush", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t3_err_cleared", 32'(err), 32'd0);
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
